byte_serializer: RTL and testbench
==================================

// Module: byte_serializer
// PURPOSE
//  Parallel-to-serial transmitter. Unloads a WIDTH-bit word captured from the
//  byte-register path and shifts it out one bit per accepted beat.
//  Upstream side uses a valid/ready word handshake; downstream side uses a
//  valid/ready bit handshake. Control is a 2-state FSM plus a bit counter.
// PARAMETERS
//  WIDTH      8  word width in bits (>=2); counter width = $clog2(WIDTH)
//  LSB_FIRST  1  1: bit 0 is sent first; 0: bit WIDTH-1 is sent first
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      upstream word valid
//  in_ready   out  1      block can accept a word (decoded from state==IDLE)
//  in_data    in   WIDTH  word to serialize, sampled when in_valid&in_ready
//  ser_out    out  1      current serial bit (0 when ser_valid=0)
//  ser_valid  out  1      ser_out holds a valid bit
//  ser_ready  in   1      downstream accepts bit when ser_valid&ser_ready
//  ser_last   out  1      high with the final bit of the word
//  done       out  1      one-cycle pulse the cycle after last bit accepted
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, shreg=0, cnt=0, done=0.
//   After reset: in_ready=1, ser_valid=0, ser_out=0, ser_last=0.
//   Reset overrides all other inputs; mid-word reset drops the word, no done.
//  States:
//   IDLE : in_ready=1, ser_valid=0. On in_valid at edge: shreg<=in_data,
//          cnt<=0, state<=SHIFT. in_valid=0 -> stay IDLE.
//   SHIFT: in_ready=0, ser_valid=1. ser_out = shreg[0] (LSB_FIRST=1) else
//          shreg[WIDTH-1]. ser_last = (cnt==WIDTH-1).
//          Beat (ser_ready=1 at edge): shift shreg by 1 toward output end
//          (fill 0), cnt<=cnt+1; if cnt==WIDTH-1: state<=IDLE, cnt<=0,
//          done<=1 next cycle.
//          ser_ready=0: shreg, cnt, ser_out, ser_last hold (no bit lost).
//  done: registered, high exactly one cycle (first IDLE cycle after word).
//  Latency: word accepted at edge N -> first bit valid in cycle N+1.
//   Min word period with ser_ready=1: WIDTH+1 cycles (one IDLE cycle between
//   words; no back-to-back overlap).
//  in_valid/in_data changes while in SHIFT are ignored (in_ready=0).
//  cnt never exceeds WIDTH-1; no wrap-around beyond word boundary.
//  ser_valid, ser_last, in_ready are pure decodes of registered state/cnt
//  (no combinational path from any input to any output).
// TESTING
//  1 LSB_FIRST=1, in_data=8'hA5, ser_ready=1 -> ser_out 1,0,1,0,0,1,0,1 on
//    cycles N+1..N+8; ser_last only on cycle N+8; done=1 on N+9; in_ready=1.
//  2 LSB_FIRST=0, in_data=8'hA5 -> ser_out 1,0,1,0,0,1,0,1 (MSB first);
//    in_data=8'h01 -> seven 0s then 1 with ser_last.
//  3 Backpressure: 8'hC3, ser_ready=0 for 3 cycles on bit 2 -> ser_out and
//    ser_last frozen those cycles; full sequence 1,1,0,0,0,0,1,1 intact,
//    done 12 cycles after accept.
//  4 in_valid=1 with 8'hFF held during SHIFT of 8'h00 -> eight 0s out,
//    8'hFF only accepted in following IDLE cycle (one-cycle gap).
//  5 rst=1 at bit 4 of 8'h5A -> next cycle ser_valid=0, in_ready=1, done=0;
//    new word 8'h0F then serializes correctly from bit 0.
//  6 Back-to-back 8'h01 then 8'h80, in_valid=1, ser_ready=1 -> two words
//    of 8 beats separated by exactly one IDLE cycle; two done pulses.

Source files
------------

// File: rtl/byte_serializer.sv
// Parallel-to-serial transmitter: takes a word on a valid/ready handshake and
// emits it one bit per accepted beat on a valid/ready bit stream.
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic             r_done;
  logic             w_done_next;
  logic             w_out_bit;
  logic             w_last;

  // The output end of the shift register depends on bit order; zeros fill in behind.
  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign w_out_bit = r_shreg[0];
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end else begin : g_msb
      assign w_out_bit = r_shreg[WIDTH-1];
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end
  endgenerate

  assign w_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shreg <= w_shreg_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shreg_next = r_shreg;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_shreg_next = in_data;
          w_cnt_next   = '0;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        // Without a beat everything holds, so a stalled bit is presented again.
        if (ser_ready) begin
          w_shreg_next = w_shifted;
          if (w_last) begin
            w_cnt_next   = '0;
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign ser_valid = (r_state == SHIFT);
  assign ser_last  = ser_valid & w_last;
  assign ser_out   = ser_valid & w_out_bit;
  assign done      = r_done;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench: an LSB-first and an MSB-first serializer share the same
// stimulus; each output stream is checked against the bit order it should emit.
module tb_byte_serializer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ser_ready;

  logic l_in_ready, l_ser_out, l_ser_valid, l_ser_last, l_done;
  logic m_in_ready, m_ser_out, m_ser_valid, m_ser_last, m_done;

  int total;
  int bad;

  byte_serializer #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_data(in_data), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .ser_ready(ser_ready), .ser_last(l_ser_last), .done(l_done)
  );

  byte_serializer #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .ser_ready(ser_ready), .ser_last(m_ser_last), .done(m_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Idle-state outputs of both instances (sampled at a negedge).
  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, " l_in_ready"}, {31'd0, l_in_ready}, 32'd1);
    chk({tag, " m_in_ready"}, {31'd0, m_in_ready}, 32'd1);
    chk({tag, " l_ser_valid"}, {31'd0, l_ser_valid}, 32'd0);
    chk({tag, " m_ser_valid"}, {31'd0, m_ser_valid}, 32'd0);
    chk({tag, " l_ser_out"}, {31'd0, l_ser_out}, 32'd0);
    chk({tag, " m_ser_out"}, {31'd0, m_ser_out}, 32'd0);
    chk({tag, " l_ser_last"}, {31'd0, l_ser_last}, 32'd0);
    chk({tag, " l_done"}, {31'd0, l_done}, {31'd0, exp_done});
    chk({tag, " m_done"}, {31'd0, m_done}, {31'd0, exp_done});
  endtask

  // Called at a negedge where the DUTs are idle. Offers word w, serializes it with
  // optional stalls on one bit, and returns at the negedge of the done cycle.
  // If has_nxt, in_valid/in_data=nxt are held throughout the shift.
  task automatic send(input string tag, input logic [7:0] w, input int stall_bit,
                      input int stall_cycles, input logic has_nxt, input logic [7:0] nxt);
    int stalls;
    in_valid  = 1'b1;
    in_data   = w;
    ser_ready = 1'b1;
    chk({tag, " accept in_ready"}, {31'd0, l_in_ready & m_in_ready}, 32'd1);
    @(negedge clk);
    in_valid = has_nxt;
    in_data  = has_nxt ? nxt : 8'h3C;
    for (int i = 0; i < 8; i++) begin
      stalls = (i == stall_bit) ? stall_cycles : 0;
      for (int k = 0; k <= stalls; k++) begin
        chk($sformatf("%s b%0d l_out", tag, i), {31'd0, l_ser_out}, {31'd0, w[i]});
        chk($sformatf("%s b%0d m_out", tag, i), {31'd0, m_ser_out}, {31'd0, w[7-i]});
        chk($sformatf("%s b%0d l_valid", tag, i), {31'd0, l_ser_valid}, 32'd1);
        chk($sformatf("%s b%0d m_valid", tag, i), {31'd0, m_ser_valid}, 32'd1);
        chk($sformatf("%s b%0d l_last", tag, i), {31'd0, l_ser_last}, {31'd0, (i == 7)});
        chk($sformatf("%s b%0d m_last", tag, i), {31'd0, m_ser_last}, {31'd0, (i == 7)});
        chk($sformatf("%s b%0d in_ready", tag, i), {31'd0, l_in_ready | m_in_ready}, 32'd0);
        chk($sformatf("%s b%0d done", tag, i), {31'd0, l_done | m_done}, 32'd0);
        ser_ready = (k == stalls);
        @(negedge clk);
      end
    end
    chk_idle({tag, " end"}, 1'b1);
    $display("word %s data=%02h stall_bit=%0d stall_cycles=%0d total=%0d bad=%0d",
             tag, w, stall_bit, stall_cycles, total, bad);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ser_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset", 1'b0);

    // A5 LSB-first 1,0,1,0,0,1,0,1; MSB-first also 1,0,1,0,0,1,0,1
    send("t1_a5", 8'hA5, -1, 0, 1'b0, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    chk_idle("t1_after", 1'b0);

    // 01: MSB-first gives seven 0s then 1 on the last bit
    send("t2_01", 8'h01, -1, 0, 1'b0, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);

    // Backpressure: 3 stall cycles on bit 2, done 12 cycles after accept
    send("t3_c3", 8'hC3, 2, 3, 1'b0, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);

    // FF held on the input while 00 shifts; taken in the done/IDLE cycle
    send("t4_00", 8'h00, -1, 0, 1'b1, 8'hFF);
    send("t4_ff", 8'hFF, -1, 0, 1'b0, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    chk_idle("t4_after", 1'b0);

    // Reset while bit 4 of 5A is on the line
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    ser_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5 b4 l_out", {31'd0, l_ser_out}, {31'd0, 1'b1});
    chk("t5 b4 m_out", {31'd0, m_ser_out}, {31'd0, 1'b1});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("t5_rst", 1'b0);
    @(negedge clk);
    chk_idle("t5_rst2", 1'b0);
    send("t5_0f", 8'h0F, -1, 0, 1'b0, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);

    // Back-to-back with in_valid held: one IDLE cycle between words, two done pulses
    send("t6_01", 8'h01, -1, 0, 1'b1, 8'h80);
    send("t6_80", 8'h80, -1, 0, 1'b0, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    chk_idle("t6_after", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
